seq_muldiv_unit: RTL and testbench
==================================

Name: seq_muldiv_unit

Overview:
- Multi-cycle signed multiply/divide unit sitting directly downstream of the 32-bit datapath bus.
- Operand A comes from the Y register output; operand B is taken straight off the bus.
- The result is produced as a 64-bit HI/LO pair, which feeds the Z register pair (Zhigh/Zlow) for later MUL/DIV write-back to HI/LO.
- The control unit drives a start/busy/done handshake and stalls while the unit is busy.

Parameters:
WIDTH, 32, operand width; results are WIDTH bits each for HI and LO.

Ports:
clk  input  1  system clock; all state updates on rising edge
clr  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only when busy=0
op  input  1  0 = signed multiply, 1 = signed divide
a_in  input  WIDTH  multiplicand / dividend (from Y register)
b_in  input  WIDTH  multiplier / divisor (from bus)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; results valid from this cycle
z_hi  output  WIDTH  product[2W-1:W] or remainder
z_lo  output  WIDTH  product[W-1:0] or quotient
div_by_zero  output  1  set with done when op=1 and b=0; held until next done

Behaviour:
- Reset (clr=1, any time, asynchronous):
  - state=IDLE, busy=0, done=0, z_hi=0, z_lo=0, div_by_zero=0, iteration count=0.
  - An operation in progress is abandoned; no done is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k captures a_in, b_in and op into internal registers, sets count=0 and moves to RUN. busy=1 from that edge.
  - RUN: one iteration per edge. After the WIDTH-th iteration (edge k+WIDTH), sign fix-up is applied and the results are registered into z_hi/z_lo at edge k+WIDTH+1. State moves to DONE at that same edge.
  - DONE: busy=0, done=1 for exactly one cycle. Next edge: start=1 behaves as in IDLE (back-to-back allowed); otherwise go to IDLE.
- Latency: done rises WIDTH+1 edges after the start edge (33 for WIDTH=32). Latency is fixed for every operand value and for divide-by-zero.
- start while busy=1 is ignored; there is no queuing.
- Operands are captured at start, so a_in/b_in may change freely afterwards.
- z_hi, z_lo and div_by_zero hold their values until the next done or clr.
- Multiply:
  - Radix-2 Booth on two's-complement operands.
  - Full 2*WIDTH signed product: {z_hi, z_lo}. No overflow is possible.
- Divide:
  - Restoring division on operand magnitudes, followed by sign correction.
  - Quotient truncates toward zero and goes to z_lo.
  - Remainder takes the sign of the dividend (or is zero) and goes to z_hi.
  - Most-negative / -1: z_lo=0x80000000 (wraps), z_hi=0, div_by_zero=0.
  - b=0: z_lo=0xFFFFFFFF, z_hi=a (captured), div_by_zero=1.
- Magnitude of the most-negative value is handled as an unsigned WIDTH-bit quantity, with no extra sign bit lost.

Decomposition:
- Shared package (muldiv_pkg) holds:
  - op encodings OP_MUL=1'b0, OP_DIV=1'b1
  - FSM state encodings IDLE/RUN/DONE
  - the count width constant, $clog2(WIDTH)+1
- One natural sub-module, muldiv_step: a combinational single-iteration datapath.
  - Booth add/sub/shift of the {acc, q, q_-1} triple, or a restoring subtract/shift of {rem, quo}, selected by op.
  - The top level keeps the FSM, counter, operand capture, sign fix-up and output registers.

Test Plan:
- Multiply 7 * -3 (a=0x00000007, b=0xFFFFFFFD, op=0) -> done at start+33, z_hi=0xFFFFFFFF, z_lo=0xFFFFFFEB, div_by_zero=0.
- Multiply 0x80000000 * 0x80000000 -> z_hi=0x40000000, z_lo=0x00000000; also check 0x7FFFFFFF*0x7FFFFFFF -> z_hi=0x3FFFFFFF, z_lo=0x00000001.
- Divide -17 / 5 -> z_lo=0xFFFFFFFD (-3), z_hi=0xFFFFFFFE (-2); divide 17 / -5 -> z_lo=0xFFFFFFFD, z_hi=0x00000002; divide 0x80000000 / 0xFFFFFFFF -> z_lo=0x80000000, z_hi=0.
- Divide 1234 / 0 -> done at start+33, div_by_zero=1, z_lo=0xFFFFFFFF, z_hi=0x000004D2; next valid op clears div_by_zero at its done.
- Handshake: second start pulsed at start+5 with different operands -> ignored, results match the first op only. start asserted in the done cycle -> new op accepted, busy=1 next cycle, second done exactly 33 edges later.
- Reset mid-op: clr asserted asynchronously at start+10 (between edges) -> busy, done, z_hi, z_lo, div_by_zero drop to 0 immediately. No done pulse follows. A fresh start after clr release completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and sizing helper for the sequential mul/div unit
package muldiv_pkg;
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, Booth add/sub/shift or restoring subtract/shift
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic             q1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n,
    output logic             q1_n
);
    logic [WIDTH:0] hx, mx, booth, shl, diff;
    // One guard bit keeps the Booth accumulator exact for most-negative operands
    always_comb begin
        hx    = op == OP_DIV ? {1'b0, hi} : {hi[WIDTH-1], hi};
        mx    = op == OP_DIV ? {1'b0, m} : {m[WIDTH-1], m};
        booth = lo[0] == q1 ? hx : lo[0] ? hx - mx : hx + mx;
        shl   = {hi, lo[WIDTH-1]};
        diff  = shl - mx;
        hi_n  = op == OP_DIV ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : booth[WIDTH:1];
        lo_n  = op == OP_DIV ? {lo[WIDTH-2:0], ~diff[WIDTH]} : {booth[0], lo[WIDTH-1:1]};
        q1_n  = op == OP_DIV ? 1'b0 : lo[0];
    end
endmodule

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: multi-cycle signed multiply/divide with start/busy/done handshake
module seq_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo,
    output logic             div_by_zero
);
    localparam int CW = cnt_width(WIDTH);
    state_t state, state_n;
    logic op_r, q1, q1_n, accept, last;
    logic [WIDTH-1:0] a_r, b_r, hi, lo, hi_n, lo_n, m, quo, rem, fix_hi, fix_lo;
    logic [CW-1:0] cnt;

    assign busy = state == RUN;
    assign done = state == DONE;
    // Magnitudes are unsigned, so |most-negative| stays exact
    assign m = op_r == OP_DIV ? (b_r[WIDTH-1] ? -b_r : b_r) : a_r;

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE, DONE: begin
                accept  = start;
                state_n = start ? RUN : IDLE;
            end
            RUN: begin
                last    = cnt == CW'(WIDTH);
                state_n = last ? DONE : RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        quo    = a_r[WIDTH-1] ^ b_r[WIDTH-1] ? -lo : lo;
        rem    = a_r[WIDTH-1] ? -hi : hi;
        fix_hi = op_r == OP_DIV ? (b_r == '0 ? a_r : rem) : hi;
        fix_lo = op_r == OP_DIV ? (b_r == '0 ? '1 : quo) : lo;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op  (op_r),
        .hi  (hi),
        .lo  (lo),
        .q1  (q1),
        .m   (m),
        .hi_n(hi_n),
        .lo_n(lo_n),
        .q1_n(q1_n)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            op_r        <= OP_MUL;
            a_r         <= '0;
            b_r         <= '0;
            hi          <= '0;
            lo          <= '0;
            q1          <= 1'b0;
            cnt         <= '0;
            z_hi        <= '0;
            z_lo        <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_r <= op;
                a_r  <= a_in;
                b_r  <= b_in;
                hi   <= '0;
                lo   <= op == OP_DIV ? (a_in[WIDTH-1] ? -a_in : a_in) : b_in;
                q1   <= 1'b0;
                cnt  <= '0;
            end else if (last) begin
                z_hi        <= fix_hi;
                z_lo        <= fix_lo;
                div_by_zero <= op_r == OP_DIV && b_r == '0;
            end else if (busy) begin
                hi  <= hi_n;
                lo  <= lo_n;
                q1  <= q1_n;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// tb_seq_muldiv_unit: randomized and directed checks against an arithmetic reference model
module tb_seq_muldiv_unit;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] z_hi, z_lo;
    int tests = 0;
    int fails = 0;

    seq_muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .op         (op),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .z_hi       (z_hi),
        .z_lo       (z_lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic o,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint p;
        int q, r;
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        if (!o) begin
            p = longint'($signed(a)) * longint'($signed(b));
            {hi, lo} = p;
        end else if (b == 32'd0) begin
            hi  = a;
            lo  = '1;
            dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
        end else begin
            q  = $signed(a) / $signed(b);
            r  = $signed(a) % $signed(b);
            hi = r;
            lo = q;
        end
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic o);
        a_in  = a;
        b_in  = b;
        op    = o;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", done); end
        tests++; if (z_hi !== 32'd0) begin fails++; $display("FAIL reset_z_hi got=%h want=0", z_hi); end
        tests++; if (z_lo !== 32'd0) begin fails++; $display("FAIL reset_z_lo got=%h want=0", z_lo); end
        tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        logic [31:0] ta [8] = '{32'h7, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFEF,
                                32'h11, 32'h8000_0000, 32'h4D2, 32'd100};
        logic [31:0] tb [8] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5,
                                32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h0, 32'd7};
        logic        to [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] eh [8] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h3FFF_FFFF, 32'hFFFF_FFFE,
                                32'h2, 32'h0, 32'h4D2, 32'd2};
        logic [31:0] el [8] = '{32'hFFFF_FFEB, 32'h0, 32'h1, 32'hFFFF_FFFD,
                                32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd14};
        logic        ed [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 8; i++) begin
            launch(ta[i], tb[i], to[i]);
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL dir%0d_busy got=%b want=1", i, busy); end
            a_in = $urandom;
            b_in = $urandom;
            wait_done(lat);
            tests++; if (lat != 33) begin fails++; $display("FAIL dir%0d_latency got=%0d want=33", i, lat); end
            tests++; if (z_hi !== eh[i]) begin fails++; $display("FAIL dir%0d_z_hi got=%h want=%h", i, z_hi, eh[i]); end
            tests++; if (z_lo !== el[i]) begin fails++; $display("FAIL dir%0d_z_lo got=%h want=%h", i, z_lo, el[i]); end
            tests++; if (div_by_zero !== ed[i]) begin fails++; $display("FAIL dir%0d_dbz got=%b want=%b", i, div_by_zero, ed[i]); end
            @(posedge clk);
            #1;
            tests++; if (done !== 1'b0) begin fails++; $display("FAIL dir%0d_done_pulse got=%b want=0", i, done); end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, eh, el;
        logic o, ed;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            o = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(0, 15)) - 32'd8;
            model(a, b, o, eh, el, ed);
            launch(a, b, o);
            wait_done(lat);
            tests++; if (lat != 33) begin fails++; $display("FAIL rnd%0d_latency got=%0d want=33", i, lat); end
            tests++; if (z_hi !== eh || z_lo !== el || div_by_zero !== ed) begin
                fails++;
                $display("FAIL rnd%0d op=%b a=%h b=%h got=%h_%h/%b want=%h_%h/%b",
                         i, o, a, b, z_hi, z_lo, div_by_zero, eh, el, ed);
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        launch(32'h7, 32'hFFFF_FFFD, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        a_in  = 32'h1234;
        b_in  = 32'h3;
        op    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        tests++; if (lat != 28) begin fails++; $display("FAIL ignore_latency got=%0d want=28", lat); end
        tests++; if (z_hi !== 32'hFFFF_FFFF || z_lo !== 32'hFFFF_FFEB) begin
            fails++; $display("FAIL ignore_result got=%h_%h want=ffffffff_ffffffeb", z_hi, z_lo);
        end
        @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_no_requeue busy=%b want=0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] eh, el;
        logic ed;
        int lat;
        launch(32'hFFFF_FFEF, 32'h5, 1'b1);
        wait_done(lat);
        tests++; if (lat != 33 || z_lo !== 32'hFFFF_FFFD || z_hi !== 32'hFFFF_FFFE) begin
            fails++; $display("FAIL b2b_first lat=%0d got=%h_%h want=33 fffffffe_fffffffd", lat, z_hi, z_lo);
        end
        model(32'h0001_2345, 32'hFFFF_0011, 1'b0, eh, el, ed);
        launch(32'h0001_2345, 32'hFFFF_0011, 1'b0);
        tests++; if (busy !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL b2b_accept busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done(lat);
        tests++; if (lat != 33) begin fails++; $display("FAIL b2b_latency got=%0d want=33", lat); end
        tests++; if (z_hi !== eh || z_lo !== el || div_by_zero !== ed) begin
            fails++; $display("FAIL b2b_second got=%h_%h/%b want=%h_%h/%b", z_hi, z_lo, div_by_zero, eh, el, ed);
        end
    endtask

    task automatic test_clr_mid_op;
        int lat, seen;
        launch(32'h4D2, 32'h0, 1'b1);
        wait_done(lat);
        launch(32'd100, 32'd7, 1'b1);
        repeat (10) @(posedge clk);
        #3 clr = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL clr_ctrl busy=%b done=%b want 0 0", busy, done);
        end
        tests++; if (z_hi !== 32'd0 || z_lo !== 32'd0 || div_by_zero !== 1'b0) begin
            fails++; $display("FAIL clr_outputs got=%h_%h/%b want=0_0/0", z_hi, z_lo, div_by_zero);
        end
        @(posedge clk);
        #1 clr = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL clr_no_done got=%0d pulses want=0", seen); end
        launch(32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_done(lat);
        tests++; if (lat != 33 || z_lo !== 32'hFFFF_FFF2 || z_hi !== 32'hFFFF_FFFE) begin
            fails++; $display("FAIL clr_fresh lat=%0d got=%h_%h want=33 fffffffe_fffffff2", lat, z_hi, z_lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_clr_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
